// File: rtl/synaptic_input_accumulator.sv
// Synaptic input accumulator: pipelined read-modify-write of the I field of the
// neuron state word. Each accepted spike event (addr, signed weight) adds its
// weight into I with saturation; v and w pass through untouched.
//
// Handshake: an event transfers in any cycle where ev_valid && ev_ready.
// ev_ready = !rst && !halt and never depends on ev_valid. Events already
// accepted always complete (a write two cycles later) unless rst intervenes,
// in which case they are dropped without writing.
//
// Stages: S0 (accept, issue RAM read), S1 (select base word, add, clamp),
// S2 (write). Forwarding from S2 and from a copy of the previous write covers
// same-address events at distance 1 and 2, so the RAM read can be stale.
module synaptic_input_accumulator #(
   parameter int NR_WIDTH      = 56,
   parameter int NR_V_WIDTH    = 20,
   parameter int NR_I_WIDTH    = 16,
   parameter int NR_ADDR_WIDTH = 10,
   parameter int W_WIDTH       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ev_valid,
   output logic                     ev_ready,
   input  logic [NR_ADDR_WIDTH-1:0] ev_addr,
   input  logic [W_WIDTH-1:0]       ev_weight,
   input  logic                     halt,
   output logic                     idle,
   output logic                     mem_rd_en,
   output logic [NR_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [NR_WIDTH-1:0]      mem_rd_data,
   output logic                     mem_wr_en,
   output logic [NR_ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [NR_WIDTH-1:0]      mem_wr_data,
   output logic                     sat_flag
);

   // One guard bit so the sum of two NR_I_WIDTH-bit signed values never wraps.
   localparam int SUM_W = NR_I_WIDTH + 1;
   localparam logic [NR_I_WIDTH-1:0] I_MAX = {1'b0, {(NR_I_WIDTH-1){1'b1}}};
   localparam logic [NR_I_WIDTH-1:0] I_MIN = {1'b1, {(NR_I_WIDTH-1){1'b0}}};

   logic                     accept;

   // S1 stage registers
   logic                     s1_valid_q, s1_valid_d;
   logic [NR_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic [W_WIDTH-1:0]       s1_weight_q, s1_weight_d;

   // S2 stage registers (the word being written this cycle)
   logic                     s2_valid_q, s2_valid_d;
   logic [NR_ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
   logic [NR_WIDTH-1:0]      s2_word_q, s2_word_d;

   // Copy of the word written in the previous cycle; the RAM read issued in
   // that same cycle returned the pre-write value, so S1 must bypass it.
   logic                     lw_valid_q, lw_valid_d;
   logic [NR_ADDR_WIDTH-1:0] lw_addr_q, lw_addr_d;
   logic [NR_WIDTH-1:0]      lw_word_q, lw_word_d;

   logic                     sat_q, sat_d;

   logic [NR_WIDTH-1:0]      base_word;
   logic [SUM_W-1:0]         i_ext;
   logic [SUM_W-1:0]         w_ext;
   logic [SUM_W-1:0]         sum;
   logic                     clamp;
   logic [NR_I_WIDTH-1:0]    new_i;

   // S0: handshake and RAM read issue, combinational from the accept
   always_comb begin
      ev_ready    = !rst && !halt;
      accept      = ev_valid && ev_ready;
      mem_rd_en   = accept;
      mem_rd_addr = ev_addr;
      s1_valid_d  = accept;
      s1_addr_d   = ev_addr;
      s1_weight_d = ev_weight;
   end

   // S1: pick the freshest copy of the target word, add weight, saturate
   always_comb begin
      base_word = mem_rd_data;
      if (lw_valid_q && (lw_addr_q == s1_addr_q)) begin
         base_word = lw_word_q;
      end
      if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
         base_word = s2_word_q;
      end
      i_ext = {base_word[NR_I_WIDTH-1], base_word[NR_I_WIDTH-1:0]};
      w_ext = {{(SUM_W-W_WIDTH){s1_weight_q[W_WIDTH-1]}}, s1_weight_q};
      sum   = i_ext + w_ext;
      // Overflow shows as disagreement between the guard bit and the I sign bit.
      clamp = sum[SUM_W-1] ^ sum[SUM_W-2];
      if (clamp) begin
         new_i = sum[SUM_W-1] ? I_MIN : I_MAX;
      end else begin
         new_i = sum[NR_I_WIDTH-1:0];
      end
      s2_valid_d = s1_valid_q;
      s2_addr_d  = s1_addr_q;
      s2_word_d  = {base_word[NR_WIDTH-1:NR_I_WIDTH], new_i};
      sat_d      = sat_q || (s1_valid_q && clamp);
   end

   // S2 bookkeeping: remember what is written this cycle for next cycle's S1
   always_comb begin
      lw_valid_d = s2_valid_q;
      lw_addr_d  = s2_addr_q;
      lw_word_d  = s2_word_q;
   end

   // Pipeline, last-write and sticky flag registers; rst drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         s1_weight_q <= '0;
         s2_valid_q  <= 1'b0;
         s2_addr_q   <= '0;
         s2_word_q   <= '0;
         lw_valid_q  <= 1'b0;
         lw_addr_q   <= '0;
         lw_word_q   <= '0;
         sat_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         s1_weight_q <= s1_weight_d;
         s2_valid_q  <= s2_valid_d;
         s2_addr_q   <= s2_addr_d;
         s2_word_q   <= s2_word_d;
         lw_valid_q  <= lw_valid_d;
         lw_addr_q   <= lw_addr_d;
         lw_word_q   <= lw_word_d;
         sat_q       <= sat_d;
      end
   end

   // Write port and status outputs; a write pending when rst arrives is suppressed
   always_comb begin
      mem_wr_en   = s2_valid_q && !rst;
      mem_wr_addr = s2_addr_q;
      mem_wr_data = s2_word_q;
      sat_flag    = sat_q;
      idle        = rst || !(s1_valid_q || s2_valid_q || accept);
   end

endmodule
